rle_encoder: RTL and testbench
==============================

RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 The block SHALL have these ports: clock, input, 1, sole clock, all logic on its rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1, synchronous, active-high.
REQ-003 The block SHALL have these ports: enable, input, 1, 1 selects RLE mode, 0 selects pass-through.
REQ-004 The block SHALL have these ports: disabledGroups, input, 4, same group-disable mask as the upstream aligner; static while sampling.
REQ-005 The block SHALL have these ports: validIn, input, 1, dataIn holds a compacted sample this cycle.
REQ-006 The block SHALL have these ports: dataIn, input, 32, compacted sample, LSB-justified.
REQ-007 The block SHALL have these ports: validOut, output, 1, dataOut valid this cycle.
REQ-008 The block SHALL have these ports: dataOut, output, 32, value word or count word.

Function
REQ-009 Active width W SHALL be 8, 16 or 24 when exactly 1, 2 or 3 groups are enabled, and 32 otherwise (including mask 4'b0000 and 4'b1111).
REQ-010 Flag bit F = W-1; compare/value field SHALL be bits [W-2:0]; bits above W-1 SHALL output 0 in RLE mode.
REQ-011 Pass-through (enable=0, no flush pending): validOut/dataOut SHALL equal validIn/dataIn delayed exactly 1 cycle, unmodified.
REQ-012 RLE value word SHALL be {F=0, sample[W-2:0]}; count word SHALL be {F=1, repeats[W-2:0]}.
REQ-013 repeats SHALL count samples equal to the last emitted value, excluding the first; MAX = 2^(W-1)-1.
REQ-014 State SHALL be: held value V, repeat counter C, one-entry pending-value register P with valid bit.
REQ-015 First valid sample after reset or after enable rises SHALL be emitted as a value word with 1-cycle latency; V is loaded and C=0.
REQ-016 A valid sample equal to V with C<MAX-1 SHALL increment C and emit nothing.
REQ-017 A valid sample equal to V with C=MAX-1 SHALL emit count word MAX and clear C to 0 (V unchanged).
REQ-018 A valid sample different from V with C=0 SHALL emit its value word. If P is valid, P SHALL be emitted first and the new word written into P.
REQ-019 A valid sample different from V with C>0 SHALL emit count word C this cycle, write the new value word into P, emit P next cycle, load V, and clear C.
REQ-020 P SHALL drain every cycle; at most one output word per cycle; no input stall exists and no sample SHALL be lost while enable=1.
REQ-021 Cycles with validIn=0 SHALL not change C or V; P still drains.
REQ-022 enable falling SHALL flush the encoder: emit count word C if C>0, then P if valid, then enter pass-through. The flush SHALL take at most 2 cycles.
REQ-023 validIn SHALL be held 0 by the controller for 2 cycles after enable falls; samples arriving during a flush SHALL be dropped.
REQ-024 enable rising SHALL clear C and P; the next sample follows REQ-015.

Reset
REQ-025 reset SHALL force validOut=0, dataOut=0, C=0, P invalid, V=0, and a first-sample pending state, effective at the next edge.
REQ-026 reset SHALL take priority over all other inputs; asserting it mid-run SHALL discard C and P without emitting them.

Structure
REQ-027 A shared package SHALL hold the width-select encoding (W8/W16/W24/W32) and the flag-bit/mask derivation function used by this block and by the controller's decoder.
REQ-028 The block SHALL instantiate one sub-module, rle_width_decode: disabledGroups -> width select, registered once.
REQ-029 The remainder SHALL be a single encoder FSM with states PASS, FIRST, RUN, FLUSH_CNT and FLUSH_VAL.

Verification
REQ-030 Pass-through: enable=0, mask 0000, dataIn=0xDEADBEEF valid -> dataOut=0xDEADBEEF, validOut=1, next cycle.
REQ-031 8-bit run: mask 1110, enable=1, samples 0x05 x5, then 0x09 -> outputs 0x05, 0x84, 0x09; 0x09 appears one cycle after 0x84.
REQ-032 Saturation: mask 1110, 129 consecutive 0x11 samples -> 0x11, then 0xFF after the 128th sample; C=0 afterwards.
REQ-033 Alternating every cycle, mask 1100, samples 0x1234, 0x0042, 0x1234 -> three value words on consecutive cycles, no count words, no drops.
REQ-034 Flush: 16-bit mode, 0x0042 x4 then enable drops -> 0x0042, 0x8003, then pass-through 1-cycle latency.
REQ-035 Mid-run reset: reset asserted with C=10 -> validOut=0 next cycle; no count word ever emitted; the next sample is a value word.

Source files
------------

// File: rtl/rle_encoder_pkg.sv
// Shared definitions for the RLE encoder and the controller-side decoder:
// active-width encoding plus the flag-bit / value-field derivation.
package rle_encoder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W24 = 2'd2,
    W32 = 2'd3
  } wsel_e;

  typedef enum logic [2:0] {
    PASS      = 3'd0,
    FIRST     = 3'd1,
    RUN       = 3'd2,
    FLUSH_CNT = 3'd3,
    FLUSH_VAL = 3'd4
  } enc_state_e;

  // A set bit in the mask disables that byte group.
  function automatic wsel_e wsel_from_mask(input logic [3:0] dis);
    logic [2:0] n_en;
    n_en = 3'd0;
    for (int i = 0; i < 4; i++) n_en = n_en + {2'b00, ~dis[i]};
    case (n_en)
      3'd1:    return W8;
      3'd2:    return W16;
      3'd3:    return W24;
      default: return W32;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] flag_bit(input wsel_e w);
    case (w)
      W8:      return 32'h0000_0080;
      W16:     return 32'h0000_8000;
      W24:     return 32'h0080_0000;
      default: return 32'h8000_0000;
    endcase
  endfunction

  // Value field is everything below the flag; also the saturation count MAX.
  function automatic logic [DATA_W-1:0] value_mask(input wsel_e w);
    return flag_bit(w) - 32'd1;
  endfunction

endpackage

// File: rtl/rle_encoder_if.sv
// Sample/word bus between the capture controller and the RLE encoder.
interface rle_encoder_if;
  import rle_encoder_pkg::*;

  logic              enable;
  logic [3:0]        disabledGroups;
  logic              validIn;
  logic [DATA_W-1:0] dataIn;
  logic              validOut;
  logic [DATA_W-1:0] dataOut;

  modport master (
    output enable, disabledGroups, validIn, dataIn,
    input  validOut, dataOut
  );

  modport slave (
    input  enable, disabledGroups, validIn, dataIn,
    output validOut, dataOut
  );
endinterface

// File: rtl/rle_width_decode.sv
// Registers the active-width select derived from the group-disable mask.
module rle_width_decode
  import rle_encoder_pkg::*;
(
  input  logic       clock,
  input  logic [3:0] disabled_groups_i,
  output wsel_e      wsel_o
);

  wsel_e wsel_q;

  // The mask is static while sampling, so a free-running register suffices.
  always_ff @(posedge clock) begin
    wsel_q <= wsel_from_mask(disabled_groups_i);
  end

  assign wsel_o = wsel_q;

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: value words with a clear flag bit, repeat-count words
// with the flag set; pass-through with one cycle of latency when disabled.
module rle_encoder
  import rle_encoder_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  rle_encoder_if.slave bus
);

  wsel_e             wsel;
  logic [DATA_W-1:0] fbit, vmask, sample;

  enc_state_e        state_q, state_d, eff_state;
  logic [DATA_W-1:0] v_q, v_d, c_q, c_d, p_q, p_d;
  logic              p_vld_q, p_vld_d;
  logic              vout_q, vout_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  rle_width_decode u_width_decode (
    .clock             (clock),
    .disabled_groups_i (bus.disabledGroups),
    .wsel_o            (wsel)
  );

  assign fbit   = flag_bit(wsel);
  assign vmask  = value_mask(wsel);
  assign sample = bus.dataIn & vmask;

  // Enable edges take effect in the same cycle they are seen.
  always_comb begin
    eff_state = state_q;
    if ((state_q == RUN) && !bus.enable)        eff_state = FLUSH_CNT;
    else if ((state_q == PASS) && bus.enable)   eff_state = FIRST;
    else if ((state_q == FIRST) && !bus.enable) eff_state = PASS;
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    c_d     = c_q;
    p_d     = p_q;
    p_vld_d = 1'b0;
    vout_d  = p_vld_q;
    dout_d  = p_vld_q ? p_q : '0;

    case (eff_state)
      PASS: begin
        state_d = PASS;
        c_d     = '0;
        vout_d  = bus.validIn;
        dout_d  = bus.dataIn;
      end

      FIRST: begin
        state_d = FIRST;
        c_d     = '0;
        vout_d  = 1'b0;
        dout_d  = '0;
        if (bus.validIn) begin
          vout_d  = 1'b1;
          dout_d  = sample;
          v_d     = sample;
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.validIn) begin
          if (sample == v_q) begin
            if (c_q == vmask - 32'd1) begin
              vout_d = 1'b1;
              dout_d = fbit | vmask;
              c_d    = '0;
            end else begin
              c_d = c_q + 32'd1;
            end
          end else if (c_q == '0) begin
            v_d = sample;
            if (p_vld_q) begin
              p_d     = sample;
              p_vld_d = 1'b1;
            end else begin
              vout_d = 1'b1;
              dout_d = sample;
            end
          end else begin
            // P is always empty while a count is pending, so it can take the new value.
            vout_d  = 1'b1;
            dout_d  = fbit | c_q;
            p_d     = sample;
            p_vld_d = 1'b1;
            v_d     = sample;
            c_d     = '0;
          end
        end
      end

      FLUSH_CNT: begin
        c_d     = '0;
        state_d = PASS;
        if (c_q != '0) begin
          vout_d  = 1'b1;
          dout_d  = fbit | c_q;
          p_vld_d = p_vld_q;
          state_d = p_vld_q ? FLUSH_VAL : PASS;
        end
      end

      FLUSH_VAL: begin
        state_d = PASS;
      end

      default: begin
        state_d = FIRST;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FIRST;
      v_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      c_q     <= c_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.validOut = vout_q;
  assign bus.dataOut  = dout_q;

endmodule

// File: tb/tb_rle_encoder.sv
// Directed and randomized bench for rle_encoder; expected words come from a
// run-list model of the encoding rules.
module tb_rle_encoder;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  int   e0, e1, w;

  logic [31:0] outq[$];
  int          outc[$];
  logic [31:0] exp_q[$];
  logic [31:0] samp_q[$];
  logic [31:0] alpha[3];
  logic [3:0]  masks[7];

  rle_encoder_if bus ();

  rle_encoder dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (!rst && bus.validOut) begin
      outq.push_back(bus.dataOut);
      outc.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] d);
    bus.validIn = v;
    bus.dataIn  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    outq.delete();
    outc.delete();
  endtask

  task automatic check_q(input string tag);
    chk({tag, ".count"}, outq.size(), exp_q.size());
    for (int i = 0; i < outq.size() && i < exp_q.size(); i++)
      chk($sformatf("%s.word%0d", tag, i), outq[i], exp_q[i]);
  endtask

  // Drop enable and let the flush and controller hold-off elapse.
  task automatic end_segment();
    bus.enable = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
  endtask

  task automatic start_segment(input logic [3:0] mask);
    bus.enable         = 1'b0;
    bus.disabledGroups = mask;
    cyc(0, 0);
    cyc(0, 0);
    clear_obs();
    bus.enable = 1'b1;
  endtask

  function automatic int width_of(input logic [3:0] mask);
    int n;
    n = 4 - $countones(mask);
    if (n == 1) return 8;
    if (n == 2) return 16;
    if (n == 3) return 24;
    return 32;
  endfunction

  // Split the sample list into runs of equal field value; each run is its value
  // word, full MAX counts, then any remaining repeats.
  task automatic build_expected(input int width);
    logic [31:0] m, flag, v;
    int          i, len;
    longint      reps;
    flag = 32'h1 << (width - 1);
    m    = flag - 32'd1;
    exp_q.delete();
    i = 0;
    while (i < samp_q.size()) begin
      v   = samp_q[i] & m;
      len = 1;
      while ((i + len < samp_q.size()) && ((samp_q[i + len] & m) == v)) len++;
      exp_q.push_back(v);
      reps = longint'(len - 1);
      while (reps >= longint'(m)) begin
        exp_q.push_back(flag | m);
        reps -= longint'(m);
      end
      if (reps > 0) exp_q.push_back(flag | 32'(reps));
      i += len;
    end
  endtask

  initial begin
    masks = '{4'b1110, 4'b1101, 4'b1100, 4'b1000, 4'b0000, 4'b1111, 4'b0110};
    rst                = 1'b1;
    bus.enable         = 1'b0;
    bus.disabledGroups = 4'b0000;
    bus.validIn        = 1'b0;
    bus.dataIn         = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.validOut", {31'd0, bus.validOut}, 32'd0);
    chk("reset.dataOut", bus.dataOut, 32'd0);
    rst = 1'b0;
    clear_obs();

    // Pass-through
    cyc(1, 32'hDEAD_BEEF);
    chk("pass.validOut", {31'd0, bus.validOut}, 32'd1);
    chk("pass.dataOut", bus.dataOut, 32'hDEAD_BEEF);
    cyc(0, 32'h1234_5678);
    chk("pass.idle.validOut", {31'd0, bus.validOut}, 32'd0);
    chk("pass.idle.dataOut", bus.dataOut, 32'h1234_5678);

    // 8-bit run then a new value
    start_segment(4'b1110);
    cyc(1, 32'h05);
    e0 = cyc_cnt;
    repeat (4) cyc(1, 32'h05);
    cyc(1, 32'h09);
    e1 = cyc_cnt;
    cyc(0, 0);
    cyc(0, 0);
    exp_q = '{32'h05, 32'h84, 32'h09};
    check_q("run8");
    if (outc.size() == 3) begin
      chk("run8.first_latency", outc[0], e0);
      chk("run8.count_cycle", outc[1], e1);
      chk("run8.value_after_count", outc[2], e1 + 1);
    end
    end_segment();

    // Saturation at MAX=127 repeats
    start_segment(4'b1110);
    for (int k = 0; k < 128; k++) cyc(1, 32'h11);
    e0 = cyc_cnt;
    cyc(0, 0);
    exp_q = '{32'h11, 32'hFF};
    check_q("sat128");
    if (outc.size() == 2) chk("sat.count_cycle", outc[1], e0);
    cyc(1, 32'h11);
    end_segment();
    exp_q = '{32'h11, 32'hFF, 32'h81};
    check_q("sat129.flush");

    // Alternating values, 16-bit
    start_segment(4'b1100);
    cyc(1, 32'h1234);
    e0 = cyc_cnt;
    cyc(1, 32'h0042);
    cyc(1, 32'h1234);
    cyc(0, 0);
    exp_q = '{32'h1234, 32'h0042, 32'h1234};
    check_q("alt16");
    if (outc.size() == 3) begin
      chk("alt16.cycle1", outc[1], e0 + 1);
      chk("alt16.cycle2", outc[2], e0 + 2);
    end
    end_segment();

    // Flush on enable fall, then pass-through
    start_segment(4'b1100);
    repeat (4) cyc(1, 32'h0042);
    bus.enable = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 32'hCAFE_F00D);
    e0 = cyc_cnt;
    cyc(0, 0);
    exp_q = '{32'h0042, 32'h8003, 32'hCAFE_F00D};
    check_q("flush16");
    if (outc.size() == 3) chk("flush16.pass_latency", outc[2], e0);

    // Mid-run reset with C=10
    start_segment(4'b1110);
    repeat (11) cyc(1, 32'h33);
    rst = 1'b1;
    cyc(0, 0);
    chk("midreset.validOut", {31'd0, bus.validOut}, 32'd0);
    chk("midreset.dataOut", bus.dataOut, 32'd0);
    rst = 1'b0;
    cyc(0, 0);
    cyc(1, 32'h33);
    cyc(0, 0);
    end_segment();
    exp_q = '{32'h33, 32'h33};
    check_q("midreset");

    // Random pass-through
    bus.enable = 1'b0;
    for (int k = 0; k < 24; k++) begin
      logic        v;
      logic [31:0] d;
      v = 1'($urandom_range(0, 1));
      d = $urandom;
      cyc(v, d);
      chk("rpass.validOut", {31'd0, bus.validOut}, {31'd0, v});
      chk("rpass.dataOut", bus.dataOut, d);
    end

    // Random RLE segments checked against the run-list model
    for (int r = 0; r < 10; r++) begin
      int n, chg;
      logic [31:0] cur;
      start_segment(masks[r % 7]);
      w        = width_of(masks[r % 7]);
      alpha[0] = $urandom;
      alpha[1] = $urandom;
      alpha[2] = alpha[0] ^ (32'hFFFF_FFFF << (w - 1));
      chg      = (r % 3 == 0) ? 1 : 25;
      n        = (r % 3 == 0) ? 400 : 150;
      samp_q.delete();
      cur = alpha[0];
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 99) < chg) cur = alpha[$urandom_range(0, 2)];
        if ($urandom_range(0, 99) < 75) begin
          cyc(1, cur);
          samp_q.push_back(cur);
        end else begin
          cyc(0, $urandom);
        end
      end
      end_segment();
      build_expected(w);
      check_q($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
